// File: rtl/mult_iter_pkg.sv
// Shared definitions for the iterative multiplier. The multi-cycle divider reuses
// the state names.
package mult_iter_pkg;
  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_CALC = 2'b01,
    MUL_FIX  = 2'b10
  } mul_state_e;
endpackage

// File: rtl/mult_iter_abs_neg.sv
// Conditional two's complement. It produces operand magnitudes and the signed
// fix-up of the 2W-bit product.
module mult_iter_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_neg_en,
  output logic [WIDTH-1:0] o_out
);
  assign o_out = i_neg_en ? (~i_in + WIDTH'(1)) : i_in;
endmodule

// File: rtl/mult_iter.sv
// Radix-2 shift-add multiplier for MULT/MULTU. It uses a fixed 33-clock latency
// from the accepted start to the done pulse, and returns the 64-bit product as hi/lo.
module mult_iter
  import mult_iter_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH);

  mul_state_e         r_state;
  mul_state_e         w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg;
  logic               r_done;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_result;
  logic               w_last;

  mult_iter_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .i_in(a), .i_neg_en(sign & a[WIDTH-1]), .o_out(w_mag_a)
  );
  mult_iter_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .i_in(b), .i_neg_en(sign & b[WIDTH-1]), .o_out(w_mag_b)
  );
  mult_iter_abs_neg #(.WIDTH(2*WIDTH)) u_fix (
    .i_in({r_acc, r_mplr}), .i_neg_en(r_neg), .o_out(w_result)
  );

  // The carry is kept as bit WIDTH and shifts back into the accumulator.
  assign w_sum  = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_last = (r_count == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MUL_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MUL_IDLE: if (start) w_next = MUL_CALC;
      MUL_CALC: if (w_last) w_next = MUL_FIX;
      MUL_FIX:  w_next = MUL_IDLE;
      default:  w_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_neg   <= 1'b0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MUL_IDLE: if (start) begin
          r_mcand <= w_mag_a;
          r_mplr  <= w_mag_b;
          r_acc   <= '0;
          r_neg   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_count <= '0;
        end
        MUL_CALC: begin
          r_acc   <= w_sum[WIDTH:1];
          r_mplr  <= {w_sum[0], r_mplr[WIDTH-1:1]};
          r_count <= r_count + CNT_W'(1);
        end
        MUL_FIX: begin
          {r_hi, r_lo} <= w_result;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != MUL_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: doc/mult_iter.md
Name: mult_iter

Overview:
- Multi-cycle radix-2 shift-add multiplier for the MIPS CPU datapath. It is the inverse-operation partner of the combinational divider and serves MULT/MULTU.
- Takes two 32-bit operands and a signed/unsigned select, and returns the 64-bit product split into hi/lo, matching the divider's lo/hi result convention.
- Sits beside the divider in the execute stage. The controller stalls on busy and writes HI/LO on done.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH split into hi/lo.

Ports:
clk    input   1      system clock, rising edge
rst_n  input   1      asynchronous, active-low reset
start  input   1      request; sampled only when idle (busy=0)
a      input   WIDTH  multiplicand, captured at accepted start
b      input   WIDTH  multiplier, captured at accepted start
sign   input   1      1 = signed (MULT), 0 = unsigned (MULTU); captured at accepted start
busy   output  1      operation in progress
done   output  1      single-cycle completion pulse
hi     output  WIDTH  upper half of product
lo     output  WIDTH  lower half of product

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - state=IDLE; busy=0, done=0, hi=0, lo=0; all internal registers 0.
  - Reset asserted mid-operation aborts it immediately, with no partial result.
- States:
  - IDLE: start=1 at edge k captures a, b and sign. Signed mode latches magnitudes |a|, |b| and neg = a[W-1]^b[W-1]; unsigned mode sets neg=0. Go to CALC, count=0, busy=1.
  - CALC: each edge, if multiplier LSB=1 add multiplicand into the upper accumulator (W+1-bit add, carry kept), then shift {carry, acc, mplr} right 1 and increment count. After the 32nd iteration (edge k+32) go to FIX.
  - FIX: at edge k+33, {hi,lo} = neg ? two's complement of 64-bit product : product. Also done=1, busy=0, state=IDLE.
- Latency: done is high in the cycle after edge k+33, i.e. 33 clocks after start is sampled. It is fixed and data-independent.
- done is high for exactly one cycle and clears automatically.
- hi/lo keep the previous result throughout CALC and change only at the FIX edge. They hold until the next FIX or reset.
- start while busy=1 is ignored. Operand changes during busy have no effect.
- start during the done cycle is accepted, because the FSM is already IDLE. This gives back-to-back operations with a 34-cycle period.
- Arithmetic rules:
  - Magnitude of 0x80000000 is 2^31 and fits unsigned W bits.
  - Full 64-bit product is exact for all inputs: no overflow, no flags.
  - Zero operand yields hi=lo=0 with the same latency.
- A state is never left stuck. Illegal state encodings return to IDLE.

Decomposition:
- Shared header/package (cpu_defs): state encodings MUL_IDLE/MUL_CALC/MUL_FIX and the default WIDTH. The divider's multi-cycle version reuses the state names.
- Optional combinational sub-module abs_neg: W-bit conditional two's-complement (in, neg_en -> out). Used for operand magnitude and, at 2W, for the result fix-up.
- Counter, accumulator and FSM stay in mult_iter.

Test Plan:
1. Unsigned, a=3, b=5, sign=0, start one cycle -> busy=1 next cycle; done one cycle high 33 clocks after start; hi=0x00000000, lo=0x0000000F.
2. Signed, a=-2 (0xFFFFFFFE), b=2, sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFC. Repeat with sign=0 -> hi=0x00000001, lo=0xFFFFFFFC.
3. Unsigned extremes, a=b=0xFFFFFFFF, sign=0 -> hi=0xFFFFFFFE, lo=0x00000001. Signed, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Signed, a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
4. Start while busy: start 7*6; 10 cycles later pulse start with a=100, b=100 -> ignored; result hi=0, lo=42 at cycle 33. Then start asserted in the done cycle with a=100, b=100 is accepted; next done 33 cycles later with lo=10000.
5. Reset mid-op: start 7*6; drop rst_n asynchronously (between edges) at cycle 15 -> busy, done, hi, lo go 0 immediately. After release, no done appears until a new start.
6. Hold check: after a result, drive random a/b/sign with start=0 for 50 cycles -> hi/lo unchanged, done stays 0.
